// File: rtl/i2c_master_seq_pkg.sv
// Shared types and constants for the i2c_master_seq sequencer.
package i2c_pkg;

   // One state per bus slot kind; START..STOP each last one or more bit slots.
   typedef enum logic [3:0] {
      StIdle,
      StStart,
      StAddr,
      StAack,
      StWr0,
      StWack0,
      StWr1,
      StWack1,
      StRd0,
      StMack,
      StRd1,
      StMnack,
      StStop,
      StDone
   } state_t;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   // Quarter-bit phases: SCL low in the LOW phases, high in the HIGH phases.
   localparam logic [1:0] PH_LOW0  = 2'd0;
   localparam logic [1:0] PH_LOW1  = 2'd1;
   localparam logic [1:0] PH_HIGH0 = 2'd2;
   localparam logic [1:0] PH_HIGH1 = 2'd3;

   // Bit slots from accept to done: full transaction and address-NACK abort.
   localparam int unsigned SLOTS_FULL      = 29;
   localparam int unsigned SLOTS_ADDR_NACK = 11;

endpackage

// File: rtl/i2c_master_seq_if.sv
// Request handshake plus open-drain bus pins of the i2c_master_seq sequencer.
// master: the sequencer itself; slave: the requester / bus environment.
interface i2c_master_seq_if;
   logic        req;
   logic        ready;
   logic        rw;
   logic [6:0]  slave_addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        done;
   logic        ack_err;
   logic        scl_o;
   logic        scl_i;
   logic        sda_oe;
   logic        sda_i;

   modport master (
      input  req, rw, slave_addr, wdata, scl_i, sda_i,
      output ready, rdata, done, ack_err, scl_o, sda_oe
   );

   modport slave (
      output req, rw, slave_addr, wdata, scl_i, sda_i,
      input  ready, rdata, done, ack_err, scl_o, sda_oe
   );
endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-bit timebase: CLK_DIV clocks per phase, four phases per bit slot.
// stall freezes the counter while in PH_HIGH0 (slave clock stretching).
module i2c_tick_gen
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       stall,
   output logic       phase_tick,
   output logic [1:0] phase
);

   localparam int unsigned CntW = $clog2(CLK_DIV);

   logic [CntW-1:0] div_q;
   logic [1:0]      phase_q;
   logic            hold;
   logic            last;

   assign hold       = stall && (phase_q == PH_HIGH0);
   assign last       = (div_q == CntW'(CLK_DIV - 1));
   assign phase_tick = en && !hold && last;
   assign phase      = phase_q;

   // Divider and phase counter; cleared whenever the sequencer is not running a slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q   <= '0;
         phase_q <= PH_LOW0;
      end else if (!en) begin
         div_q   <= '0;
         phase_q <= PH_LOW0;
      end else if (!hold) begin
         if (last) begin
            div_q   <= '0;
            phase_q <= phase_q + 2'd1;
         end else begin
            div_q <= div_q + CntW'(1);
         end
      end
   end

endmodule

// File: rtl/i2c_master_seq.sv
// Single-master I2C transaction sequencer: START, address+R/W, two data bytes, STOP.
// Optional macro I2C_CLK_STRETCH_EN: honour slave clock stretching via scl_i.
module i2c_master_seq
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned ADDR_W  = 7
) (
   input logic               clk,
   input logic               rst,
   i2c_master_seq_if.master  bus
);

   state_t state_q, state_d;

   logic [ADDR_W-1:0] addr_q;
   logic              rw_q;
   logic [15:0]       wdata_q;
   logic [7:0]        sh_q;
   logic [2:0]        bit_cnt_q;
   logic              ack_smp_q;
   logic [15:0]       rx_q;
   logic [15:0]       rdata_q;
   logic              ack_err_q;

   logic       ready_s, done_s, scl_s, sda_s;
   logic       accept, tick_en, stall;
   logic       phase_tick;
   logic [1:0] phase;
   logic       slot_end, smp;

   assign ready_s  = (state_q == StIdle) || (state_q == StDone);
   assign accept   = bus.req && ready_s;
   assign tick_en  = !ready_s;
   assign slot_end = phase_tick && (phase == PH_HIGH1);
   // Sample point is the PH_HIGH0 -> PH_HIGH1 boundary.
   assign smp      = phase_tick && (phase == PH_HIGH0);

`ifdef I2C_CLK_STRETCH_EN
   assign stall = ~bus.scl_i;
`else
   assign stall = 1'b0;
   logic unused_scl_i;
   assign unused_scl_i = bus.scl_i;
`endif

   i2c_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk        (clk),
      .rst        (rst),
      .en         (tick_en),
      .stall      (stall),
      .phase_tick (phase_tick),
      .phase      (phase)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and bus pin decode.
   always_comb begin
      state_d = state_q;
      scl_s   = 1'b1;
      sda_s   = 1'b0;
      done_s  = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) state_d = StStart;
         end
         StStart: begin
            // SCL stays high; SDA falls halfway through the slot.
            sda_s = phase[1];
            if (slot_end) state_d = StAddr;
         end
         StAddr: begin
            scl_s = phase[1];
            sda_s = ~sh_q[7];
            if (slot_end && bit_cnt_q == 3'd7) state_d = StAack;
         end
         StAack: begin
            scl_s = phase[1];
            if (slot_end) begin
               if (ack_smp_q)            state_d = StStop;
               else if (rw_q == RW_READ) state_d = StRd0;
               else                      state_d = StWr0;
            end
         end
         StWr0: begin
            scl_s = phase[1];
            sda_s = ~sh_q[7];
            if (slot_end && bit_cnt_q == 3'd7) state_d = StWack0;
         end
         StWack0: begin
            scl_s = phase[1];
            if (slot_end) state_d = ack_smp_q ? StStop : StWr1;
         end
         StWr1: begin
            scl_s = phase[1];
            sda_s = ~sh_q[7];
            if (slot_end && bit_cnt_q == 3'd7) state_d = StWack1;
         end
         StWack1: begin
            scl_s = phase[1];
            if (slot_end) state_d = StStop;
         end
         StRd0: begin
            scl_s = phase[1];
            if (slot_end && bit_cnt_q == 3'd7) state_d = StMack;
         end
         StMack: begin
            scl_s = phase[1];
            sda_s = 1'b1;
            if (slot_end) state_d = StRd1;
         end
         StRd1: begin
            scl_s = phase[1];
            if (slot_end && bit_cnt_q == 3'd7) state_d = StMnack;
         end
         StMnack: begin
            scl_s = phase[1];
            if (slot_end) state_d = StStop;
         end
         StStop: begin
            // SDA held low, released in the last phase while SCL is high.
            scl_s = phase[1];
            sda_s = (phase != PH_HIGH1);
            if (slot_end) state_d = StDone;
         end
         StDone: begin
            done_s  = 1'b1;
            state_d = accept ? StStart : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Request capture, shift registers, sampled bits and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= '0;
         rw_q      <= RW_WRITE;
         wdata_q   <= '0;
         sh_q      <= '0;
         bit_cnt_q <= '0;
         ack_smp_q <= 1'b0;
         rx_q      <= '0;
         rdata_q   <= '0;
         ack_err_q <= 1'b0;
      end else begin
         if (accept) begin
            addr_q    <= bus.slave_addr;
            rw_q      <= bus.rw;
            wdata_q   <= bus.wdata;
            ack_err_q <= 1'b0;
         end
         if (smp) begin
            ack_smp_q <= bus.sda_i;
            if (state_q == StRd0 || state_q == StRd1) rx_q <= {rx_q[14:0], bus.sda_i};
         end
         if (slot_end) begin
            case (state_q)
               StStart: begin
                  sh_q      <= {addr_q, rw_q};
                  bit_cnt_q <= '0;
               end
               StAddr, StWr0, StWr1: begin
                  sh_q      <= {sh_q[6:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
               end
               StAack: begin
                  if (ack_smp_q) ack_err_q <= 1'b1;
                  else           sh_q      <= wdata_q[15:8];
               end
               StWack0: begin
                  if (ack_smp_q) ack_err_q <= 1'b1;
                  else           sh_q      <= wdata_q[7:0];
               end
               StWack1: begin
                  if (ack_smp_q) ack_err_q <= 1'b1;
               end
               StRd0: begin
                  bit_cnt_q <= bit_cnt_q + 3'd1;
               end
               StRd1: begin
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) rdata_q <= rx_q;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.ready   = ready_s;
   assign bus.done    = done_s;
   assign bus.rdata   = rdata_q;
   assign bus.ack_err = ack_err_q;
   assign bus.scl_o   = scl_s;
   assign bus.sda_oe  = sda_s;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Bench for i2c_master_seq: a bus-level I2C slave model plus a transaction-level
// reference for latency, captured bytes, rdata and ack_err.
module tb_i2c_master_seq;
   import i2c_pkg::*;

   localparam int unsigned CLK_DIV = 4;
   localparam int SlotClks = 4 * CLK_DIV;
   localparam int Budget   = (SLOTS_FULL + SLOTS_ADDR_NACK) * SlotClks;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   i2c_master_seq_if bus ();

   i2c_master_seq #(
      .CLK_DIV (CLK_DIV),
      .ADDR_W  (7)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic stretch = 1'b0;
   logic slave_low;
   assign bus.scl_i = bus.scl_o & ~stretch;
   assign bus.sda_i = ~bus.sda_oe & ~slave_low;

   int checks = 0;
   int errors = 0;

   // Slave configuration: nack_at 0 none, 1 address, 2 first write byte, 3 second.
   int         cfg_nack_at = 0;
   logic [7:0] cfg_rd0 = 8'h00;
   logic [7:0] cfg_rd1 = 8'h00;

   // Slave state: bits seen on each SCL rising edge since the last START.
   logic prev_scl, prev_sda;
   int   rise_cnt;
   int   stop_cnt = 0;
   logic bits [0:39];

   function automatic logic slave_drive(input int n);
      if (n == 8) return (cfg_nack_at != 1);
      if (cfg_nack_at == 1) return 1'b0;
      if (bits[7] == RW_READ) begin
         if (n >= 9 && n <= 16) return ~cfg_rd0[16-n];
         if (n >= 18 && n <= 25) return ~cfg_rd1[25-n];
         return 1'b0;
      end
      if (n == 17) return (cfg_nack_at != 2);
      if (n == 26) return (cfg_nack_at != 3);
      return 1'b0;
   endfunction

   function automatic logic [7:0] cap_byte(input int base);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[7-i] = bits[base+i];
      return b;
   endfunction

   // Bus-level slave: detects START/STOP, records bits, drives ACK/read data after SCL falls.
   always @(negedge clk) begin
      if (rst) begin
         slave_low <= 1'b0;
         rise_cnt  <= 0;
         prev_scl  <= 1'b1;
         prev_sda  <= 1'b1;
      end else begin
         prev_scl <= bus.scl_i;
         prev_sda <= bus.sda_i;
         if (bus.scl_i && prev_scl && (bus.sda_i != prev_sda)) begin
            if (!bus.sda_i) begin
               rise_cnt <= 0;
            end else begin
               stop_cnt  <= stop_cnt + 1;
               slave_low <= 1'b0;
            end
         end else if (bus.scl_i && !prev_scl) begin
            if (rise_cnt < 40) bits[rise_cnt] <= bus.sda_i;
            rise_cnt <= rise_cnt + 1;
         end else if (!bus.scl_i && prev_scl) begin
            slave_low <= slave_drive(rise_cnt);
         end
      end
   end

   logic [15:0] exp_rdata = 16'h0000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_req(input logic [6:0] a, input logic r, input logic [15:0] w);
      @(negedge clk);
      check("ready_before_req", bus.ready, 1);
      bus.req        = 1'b1;
      bus.rw         = r;
      bus.slave_addr = a;
      bus.wdata      = w;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      check("ready_drop_after_accept", bus.ready, 0);
   endtask

   // Counts clock edges after the accepting edge until done is seen.
   task automatic wait_done(input int start_cyc, input int st_at, input int st_len,
                            output int lat);
      int cyc;
      cyc = start_cyc;
      lat = -1;
      while (cyc < Budget) begin
         @(posedge clk);
         cyc++;
         #1;
         if (st_len > 0 && cyc == st_at) stretch = 1'b1;
         if (st_len > 0 && cyc == st_at + st_len) stretch = 1'b0;
         if (bus.done === 1'b1) begin
            lat = cyc;
            break;
         end
      end
   endtask

   // Reference: each completed byte costs 9 slots, plus one START and one STOP slot.
   task automatic expect_result(input logic [6:0] a, input logic r, input logic [15:0] w,
                                input int nack_at, input logic [7:0] rd0,
                                input logic [7:0] rd1, input int st_len, input int lat,
                                input int stop0);
      int nbytes;
      if (nack_at == 1)      nbytes = 1;
      else if (r)            nbytes = 3;
      else if (nack_at == 2) nbytes = 2;
      else                   nbytes = 3;
      check("latency", lat, (2 + 9 * nbytes) * SlotClks + st_len);
      check("ready_with_done", bus.ready, 1);
      check("ack_err", bus.ack_err, (nack_at != 0));
      if (r && nack_at == 0) exp_rdata = {rd0, rd1};
      check("rdata", bus.rdata, exp_rdata);
      check("addr_byte", cap_byte(0), {a, r});
      check("stop_seen", stop_cnt, stop0 + 1);
      if (!r && nbytes >= 2) check("wbyte0", cap_byte(9), w[15:8]);
      if (!r && nbytes == 3) check("wbyte1", cap_byte(18), w[7:0]);
      if (r && nbytes == 3) begin
         check("master_ack", bits[17], 0);
         check("master_nack", bits[26], 1);
      end
   endtask

   task automatic run_txn(input logic [6:0] a, input logic r, input logic [15:0] w,
                          input int nack_at, input logic [7:0] rd0, input logic [7:0] rd1,
                          input int st_at, input int st_len);
      int lat, stop0, aerr;
      cfg_nack_at = nack_at;
      cfg_rd0     = rd0;
      cfg_rd1     = rd1;
      stop0       = stop_cnt;
      start_req(a, r, w);
      wait_done(0, st_at, st_len, lat);
      expect_result(a, r, w, nack_at, rd0, rd1, st_len, lat, stop0);
      aerr = (nack_at != 0) ? 1 : 0;
      @(posedge clk);
      #1;
      check("done_one_cycle", bus.done, 0);
      check("ack_err_holds", bus.ack_err, aerr);
   endtask

   initial begin
      int lat, stop0;
      logic [6:0]  ra;
      logic        rr;
      logic [15:0] rw16;
      int          rn;

      bus.req        = 1'b0;
      bus.rw         = 1'b0;
      bus.slave_addr = 7'h00;
      bus.wdata      = 16'h0000;

      #1;
      check("rst_ready", bus.ready, 1);
      check("rst_done", bus.done, 0);
      check("rst_ack_err", bus.ack_err, 0);
      check("rst_rdata", bus.rdata, 16'h0000);
      check("rst_scl", bus.scl_o, 1);
      check("rst_sda_oe", bus.sda_oe, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Directed: write, read, address NACK on read.
      run_txn(7'h50, RW_WRITE, 16'hA55A, 0, 8'h00, 8'h00, 0, 0);
      run_txn(7'h50, RW_READ, 16'h0000, 0, 8'h3C, 8'hC3, 0, 0);
      run_txn(7'h50, RW_READ, 16'h0000, 1, 8'h12, 8'h34, 0, 0);
      run_txn(7'h2A, RW_WRITE, 16'h1234, 2, 8'h00, 8'h00, 0, 0);

      // Busy req ignored, then req held at done accepted on that edge.
      cfg_nack_at = 0;
      cfg_rd0     = 8'h96;
      cfg_rd1     = 8'h69;
      stop0       = stop_cnt;
      start_req(7'h33, RW_WRITE, 16'hBEEF);
      repeat (50) @(posedge clk);
      @(negedge clk);
      bus.req        = 1'b1;
      bus.rw         = RW_READ;
      bus.slave_addr = 7'h11;
      bus.wdata      = 16'hFFFF;
      @(negedge clk);
      bus.req = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk);
      bus.req        = 1'b1;
      bus.rw         = RW_READ;
      bus.slave_addr = 7'h44;
      bus.wdata      = 16'h0000;
      wait_done(151, 0, 0, lat);
      expect_result(7'h33, RW_WRITE, 16'hBEEF, 0, 8'h00, 8'h00, 0, lat, stop0);
      stop0 = stop_cnt;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      check("b2b_accepted", bus.ready, 0);
      wait_done(0, 0, 0, lat);
      expect_result(7'h44, RW_READ, 16'h0000, 0, 8'h96, 8'h69, 0, lat, stop0);

      // Reset in the middle of a write.
      cfg_nack_at = 0;
      start_req(7'h5A, RW_WRITE, 16'h0F0F);
      repeat (12 * SlotClks + 5) @(posedge clk);
      #1;
      check("pre_rst_scl_low", bus.scl_o, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_scl", bus.scl_o, 1);
      check("mid_rst_sda_oe", bus.sda_oe, 0);
      check("mid_rst_ready", bus.ready, 1);
      check("mid_rst_rdata", bus.rdata, 16'h0000);
      exp_rdata = 16'h0000;
      @(negedge clk);
      rst = 1'b0;
      run_txn(7'h5A, RW_WRITE, 16'hC0DE, 0, 8'h00, 8'h00, 0, 0);

`ifdef I2C_CLK_STRETCH_EN
      // Slave holds SCL low for 20 clocks from the start of the high half of ADDR bit 2.
      run_txn(7'h50, RW_WRITE, 16'hA55A, 0, 8'h00, 8'h00, 3 * SlotClks + 8, 20);
`endif

      // Randomized transactions.
      for (int k = 0; k < 10; k++) begin
         ra   = 7'($urandom_range(0, 127));
         rr   = 1'($urandom_range(0, 1));
         rw16 = 16'($urandom);
         if (rr) rn = ($urandom_range(0, 3) == 0) ? 1 : 0;
         else    rn = int'($urandom_range(0, 3));
         run_txn(ra, rr, rw16, rn, 8'($urandom), 8'($urandom), 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_master_seq.md
Name: i2c_master_seq

Overview:
Single-master I2C transaction sequencer that drives the SCL/SDA bus toward the slave under test.
- Per request it runs one fixed-format transaction: START, 7-bit address + R/W, two data bytes (written or read), STOP.
- Writes send the two 8-bit data packs; reads return a 16-bit word.
- A per-transaction acknowledge-error flag is reported and consumed by the scoreboard.

Parameters:
CLK_DIV, 4, clk cycles per quarter-bit phase (one SCL bit slot = 4*CLK_DIV clks); legal range ≥ 2.
ADDR_W, 7, slave address width (fixed 7; parameter kept for checking only).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
req  input  1  transaction request, sampled while ready=1
ready  output  1  idle, can accept req
rw  input  1  0 = write, 1 = read; captured with req
slave_addr  input  7  target address; captured with req
wdata  input  16  write data; [15:8] first byte, [7:0] second; captured with req
rdata  output  16  read data; [15:8] first received byte
done  output  1  one-cycle pulse at transaction end
ack_err  output  1  valid with done; 1 if any slave ACK slot read high
scl_o  output  1  SCL level driven by master
scl_i  input  1  sensed SCL (used only with stretch feature)
sda_oe  output  1  1 = pull SDA low, 0 = release (open drain)
sda_i  input  1  sensed SDA

Behaviour:
- Reset (async, immediate): ready=1, done=0, ack_err=0, rdata=0, scl_o=1, sda_oe=0, FSM=IDLE, phase counter=0. Reset mid-transaction aborts with no STOP generated.
- Handshake:
  - req&&ready accepted on that clk edge; rw/slave_addr/wdata latched; ready drops next cycle.
  - req while ready=0 is ignored (not queued).
- Bit slot: 4 phases of CLK_DIV clks each. SCL low in phases 0-1, high in phases 2-3.
  - Master changes sda_oe only at phase 0 start.
  - Master samples sda_i at the phase 2 to phase 3 boundary.
- FSM: IDLE→START→ADDR(8 slots: addr MSB first, then rw)→AACK→{WR0,WACK0,WR1,WACK1 | RD0,MACK,RD1,MNACK}→STOP→DONE→IDLE.
  - START slot: SCL held high; SDA falls at phase 2.
  - STOP slot: SDA low, then released at phase 3 while SCL is high.
  - AACK/WACKx: sda_oe=0; sampled sda_i=1 sets ack_err and jumps directly to STOP.
  - RD bytes: sda_oe=0; bits shifted MSB first. MACK drives low (ACK); MNACK releases (NACK).
  - rdata updated at the end of RD1 only. rdata is unchanged on an aborted read or on any write.
- Latency (CLK_DIV=4, no stretching): full transaction = 29 slots = 464 clks from accepting edge to done pulse; address NACK = 11 slots = 176 clks.
- done is high exactly 1 cycle, in DONE state; ready=1 returns the same cycle. ack_err holds until the next accept, then clears.
- Back-to-back: req held high with done is accepted the following cycle.

Optional Feature:
Macro I2C_CLK_STRETCH_EN.
- Defined: in phase 2, the phase counter freezes while scl_i=0 (slave stretching); the slot resumes when scl_i goes high. Latency grows by the stretch length.
- Undefined: scl_i is ignored and timing is fixed as above.

Decomposition:
- Package i2c_pkg holds:
  - FSM state enum
  - RW_WRITE=0 and RW_READ=1 constants
  - phase index constants PH_LOW0..PH_HIGH1
  - slot-count constants (29 full, 11 address abort)
- Sub-module i2c_tick_gen: CLK_DIV counter and 2-bit phase counter with a stall input for stretching; outputs a phase_tick and the phase number.

Test Plan:
- Write addr=0x50, wdata=0xA55A, slave ACKs all → bus model captures bytes 0xA0, 0xA5, 0x5A; done at +464 clks; ack_err=0.
- Read addr=0x50, slave returns 0x3C then 0xC3 → rdata=0x3CC3; master ACK after byte 1, NACK after byte 2; ack_err=0.
- Address NACK (sda_i high in AACK) → STOP follows immediately; done at +176 clks; ack_err=1; rdata unchanged.
- Second req during busy, then req held at done → first ignored; next transaction accepted the cycle after done.
- rst asserted at slot 12 of a write → same cycle: scl_o=1, sda_oe=0, ready=1; fresh write afterwards completes normally.
- With I2C_CLK_STRETCH_EN, scl_i held low 20 clks in an ADDR bit → done at +484 clks; data correct.
